// File: rtl/osc_fmt_pkg.sv
// Shared definitions for the oscillator frame formatter: FSM state encoding
// and the ASCII code points used to build the text line.
package osc_fmt_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HEX_A   = 3'd1,
    SEP     = 3'd2,
    HEX_B   = 3'd3,
    CHK_SEP = 3'd4,
    CHK     = 3'd5,
    CR      = 3'd6,
    LF      = 3'd7
  } fmt_state_e;

  localparam logic [7:0] ASC_SP   = 8'h20;
  localparam logic [7:0] ASC_CR   = 8'h0D;
  localparam logic [7:0] ASC_LF   = 8'h0A;
  localparam logic [7:0] ASC_0    = 8'h30;
  localparam logic [7:0] ASC_A_UC = 8'h41;
  localparam logic [7:0] ASC_A_LC = 8'h61;

endpackage

// File: rtl/osc_hex_ascii.sv
// Combinational nibble to ASCII hex digit converter.
// UPPERCASE selects 'A'-'F' (nonzero) or 'a'-'f' (zero) for values 10-15.
module osc_hex_ascii
  import osc_fmt_pkg::*;
#(
  parameter int UPPERCASE = 1
) (
  input  logic [3:0] nib,
  output logic [7:0] ascii
);

  // Map 0-9 onto '0'-'9' and 10-15 onto the selected letter range.
  always_comb begin
    ascii = 8'h00;
    if (nib < 4'd10) begin
      ascii = ASC_0 + {4'h0, nib};
    end else if (UPPERCASE != 0) begin
      ascii = ASC_A_UC + ({4'h0, nib} - 8'd10);
    end else begin
      ascii = ASC_A_LC + ({4'h0, nib} - 8'd10);
    end
  end

endmodule

// File: rtl/osc_frame_fmt.sv
// Oscillator counter frame formatter.
// Captures {cnt_3v3, cnt_2v5} on sample_i and streams the ASCII line
// "HHHH.. HHHH..\r\n" as a valid/ready byte stream for a UART.
// Optional build macro OSC_FMT_CHKSUM_EN appends " XX" (byte-wise XOR of the
// captured sample) before CR LF.
// All outputs are registered; each register loads from the decoded next state,
// so the first digit appears one cycle after the sample strobe.
module osc_frame_fmt
  import osc_fmt_pkg::*;
#(
  parameter int CH_W      = 32,
  parameter int UPPERCASE = 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              sample_i,
  input  logic [2*CH_W-1:0] sample_data_i,
  output logic [7:0]        tx_data_o,
  output logic              tx_valid_o,
  input  logic              tx_ready_i,
  output logic              busy_o,
  output logic              frame_done_o,
  output logic              overrun_o,
  input  logic              ovr_clr_i
);

  localparam int NDIG  = CH_W / 4;
  localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [IDX_W-1:0] IDX_TOP  = IDX_W'(NDIG - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};

  fmt_state_e          state_r, next_state_s;
  logic [2*CH_W-1:0]   cap_r, next_cap_s;
  logic [IDX_W-1:0]    idx_r, next_idx_s;
  logic [7:0]          tx_data_r, next_data_s;
  logic                tx_valid_r;
  logic                busy_r;
  logic                done_r;
  logic                ovr_r;
  logic                ovr_set_s;
  logic                fire_s;
  logic [CH_W-1:0]     hex_src_s;
  logic [3:0]          nib_s;
  logic [7:0]          asc_s;

  assign fire_s = tx_valid_r & tx_ready_i;

`ifdef OSC_FMT_CHKSUM_EN
  logic [7:0] chk_s;

  // XOR of every byte of the captured sample.
  function automatic logic [7:0] byte_xor(input logic [2*CH_W-1:0] v);
    logic [7:0] acc;
    acc = 8'h00;
    for (int i = 0; i < (2 * CH_W) / 8; i++) begin
      acc = acc ^ v[i*8 +: 8];
    end
    return acc;
  endfunction

  assign chk_s = byte_xor(next_cap_s);
`endif

  // State, capture and digit-index registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r <= IDLE;
      cap_r   <= {(2*CH_W){1'b0}};
      idx_r   <= IDX_ZERO;
    end else begin
      state_r <= next_state_s;
      cap_r   <= next_cap_s;
      idx_r   <= next_idx_s;
    end
  end

  // Next-state logic: advance only on an accepted byte; LF acceptance may
  // chain straight into a new frame when a sample arrives in that cycle.
  always_comb begin
    next_state_s = state_r;
    next_cap_s   = cap_r;
    next_idx_s   = idx_r;
    ovr_set_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (sample_i) begin
          next_state_s = HEX_A;
          next_cap_s   = sample_data_i;
          next_idx_s   = IDX_TOP;
        end else begin
          next_state_s = IDLE;
        end
      end
      HEX_A: begin
        if (fire_s && (idx_r == IDX_ZERO)) begin
          next_state_s = SEP;
        end else if (fire_s) begin
          next_idx_s = idx_r - IDX_ONE;
        end else begin
          next_idx_s = idx_r;
        end
      end
      SEP: begin
        if (fire_s) begin
          next_state_s = HEX_B;
          next_idx_s   = IDX_TOP;
        end else begin
          next_state_s = SEP;
        end
      end
      HEX_B: begin
        if (fire_s && (idx_r == IDX_ZERO)) begin
`ifdef OSC_FMT_CHKSUM_EN
          next_state_s = CHK_SEP;
`else
          next_state_s = CR;
`endif
        end else if (fire_s) begin
          next_idx_s = idx_r - IDX_ONE;
        end else begin
          next_idx_s = idx_r;
        end
      end
`ifdef OSC_FMT_CHKSUM_EN
      CHK_SEP: begin
        if (fire_s) begin
          next_state_s = CHK;
          next_idx_s   = IDX_ONE;
        end else begin
          next_state_s = CHK_SEP;
        end
      end
      CHK: begin
        if (fire_s && (idx_r == IDX_ZERO)) begin
          next_state_s = CR;
        end else if (fire_s) begin
          next_idx_s = idx_r - IDX_ONE;
        end else begin
          next_idx_s = idx_r;
        end
      end
`endif
      CR: begin
        if (fire_s) begin
          next_state_s = LF;
        end else begin
          next_state_s = CR;
        end
      end
      LF: begin
        if (fire_s && sample_i) begin
          next_state_s = HEX_A;
          next_cap_s   = sample_data_i;
          next_idx_s   = IDX_TOP;
        end else if (fire_s) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = LF;
        end
      end
      default: begin
        next_state_s = IDLE;
        next_idx_s   = IDX_ZERO;
      end
    endcase
    // A strobe while busy is dropped, except the one that chains off the LF.
    if (sample_i && (state_r != IDLE) && !((state_r == LF) && fire_s)) begin
      ovr_set_s = 1'b1;
    end else begin
      ovr_set_s = 1'b0;
    end
  end

  // Select the nibble that the next state will present.
  always_comb begin
    hex_src_s = next_cap_s[CH_W-1:0];
    nib_s     = 4'h0;
    if (next_state_s == HEX_A) begin
      hex_src_s = next_cap_s[2*CH_W-1:CH_W];
    end else begin
      hex_src_s = next_cap_s[CH_W-1:0];
    end
`ifdef OSC_FMT_CHKSUM_EN
    if (next_state_s == CHK) begin
      nib_s = next_idx_s[0] ? chk_s[7:4] : chk_s[3:0];
    end else begin
      nib_s = hex_src_s[{next_idx_s, 2'b00} +: 4];
    end
`else
    nib_s = hex_src_s[{next_idx_s, 2'b00} +: 4];
`endif
  end

  osc_hex_ascii #(
    .UPPERCASE(UPPERCASE)
  ) u_hex (
    .nib  (nib_s),
    .ascii(asc_s)
  );

  // Output byte decode for the next state.
  always_comb begin
    next_data_s = 8'h00;
    case (next_state_s)
      HEX_A, HEX_B: next_data_s = asc_s;
      SEP:          next_data_s = ASC_SP;
`ifdef OSC_FMT_CHKSUM_EN
      CHK_SEP:      next_data_s = ASC_SP;
      CHK:          next_data_s = asc_s;
`endif
      CR:           next_data_s = ASC_CR;
      LF:           next_data_s = ASC_LF;
      IDLE:         next_data_s = 8'h00;
      default:      next_data_s = 8'h00;
    endcase
  end

  // Registered stream outputs, frame-done pulse and sticky overrun (set wins).
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tx_data_r  <= 8'h00;
      tx_valid_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      ovr_r      <= 1'b0;
    end else begin
      tx_data_r  <= next_data_s;
      tx_valid_r <= (next_state_s != IDLE);
      busy_r     <= (next_state_s != IDLE);
      done_r     <= (state_r == LF) && fire_s;
      ovr_r      <= ovr_set_s | (ovr_r & ~ovr_clr_i);
    end
  end

  assign tx_data_o    = tx_data_r;
  assign tx_valid_o   = tx_valid_r;
  assign busy_o       = busy_r;
  assign frame_done_o = done_r;
  assign overrun_o    = ovr_r;

endmodule
